// File: rtl/fpmul_stim_pkg.sv
// Shared types and helpers for the FP multiplier operand source / result collector.
package fpmul_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } op_pair_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [7:0]  EXP_BASE  = 8'h78;

    // Right-shifting Galois step: the feedback mask is applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Exponent confined to 0x78..0x87 so every product stays a normal number.
    function automatic logic [31:0] make_operand(input logic [31:0] s);
        logic [7:0] exp_field;
        exp_field = EXP_BASE + {4'h0, s[26:23]};
        return {s[31], exp_field, s[22:0]};
    endfunction

endpackage

// File: rtl/fpmul_tag_fifo.sv
// In-order FIFO of issued operand pairs; a pop and a push may share a cycle even when full.
module fpmul_tag_fifo
    import fpmul_stim_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  op_pair_t push_data,
    input  logic     pop,
    output op_pair_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    op_pair_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_W);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fpmul_stim_source.sv
// Operand source and result collector for the FP multiplier valid/ready wrapper.
module fpmul_stim_source
    import fpmul_stim_pkg::*;
#(
    parameter int          NUM_OPS    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] SEED_A     = 32'hACE12468,
    parameter logic [31:0] SEED_B     = 32'h1357BDF9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic [31:0] res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic [31:0] log_a,
    output logic [31:0] log_b,
    output logic [31:0] log_z,
    output logic        log_valid,
    output logic [15:0] issued_cnt,
    output logic [15:0] received_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] NUM_OPS_W = 16'(NUM_OPS);
    localparam logic [15:0] LAST_OP   = 16'(NUM_OPS - 1);

    state_t      state;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic        fifo_full;
    logic        fifo_empty;
    op_pair_t    fifo_head;
    op_pair_t    push_pair;
    logic        op_xfer;
    logic        res_xfer;
    logic        pop_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign op_a = make_operand(lfsr_a);
    assign op_b = make_operand(lfsr_b);

    // Decoded from registers only; full and the count change solely on a transfer, so an offer is never withdrawn.
    assign op_valid  = (state == ISSUE) && (issued_cnt < NUM_OPS_W) && !fifo_full;
    assign res_ready = (state == ISSUE) || (state == DRAIN);
    assign busy      = res_ready;
    assign done      = (state == DONE);

    assign op_xfer   = op_valid && op_ready;
    assign res_xfer  = res_valid && res_ready;
    assign pop_ok    = res_xfer && !fifo_empty;
    assign push_pair = '{a: op_a, b: op_b};

    fpmul_tag_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (op_xfer),
        .push_data (push_pair),
        .pop       (pop_ok),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            issued_cnt   <= '0;
            received_cnt <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ISSUE;
                        issued_cnt   <= '0;
                        received_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (op_xfer && (issued_cnt == LAST_OP)) state <= DRAIN;
                end
                DRAIN: begin
                    if (received_cnt == NUM_OPS_W) state <= DONE;
                end
                default: state <= IDLE;
            endcase
            if (op_xfer) issued_cnt <= sat_inc(issued_cnt);
            if (pop_ok)  received_cnt <= sat_inc(received_cnt);
            // A result with nothing outstanding cannot be paired; drop it and flag it.
            if (res_xfer && fifo_empty) err <= 1'b1;
        end
    end

    // LFSRs move only on an accepted operand pair and survive start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (op_xfer) begin
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_a     <= '0;
            log_b     <= '0;
            log_z     <= '0;
        end else begin
            log_valid <= pop_ok;
            if (pop_ok) begin
                log_a <= fifo_head.a;
                log_b <= fifo_head.b;
                log_z <= res_data;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_stim_source.sv
// Directed bench for fpmul_stim_source with a latency-modelling multiplier responder and scoreboard.
`timescale 1ns/1ps
module tb_fpmul_stim_source;

    localparam int          NUM_OPS    = 6;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] SEED_A     = 32'hACE12468;
    localparam logic [31:0] SEED_B     = 32'h1357BDF9;
    localparam logic [31:0] POLY       = 32'h80200003;
    localparam int          LAT        = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_ready = 1'b0;
    logic [31:0] op_a, op_b, res_data, log_a, log_b, log_z;
    logic        op_valid, res_valid, res_ready, log_valid, busy, done, err;
    logic [15:0] issued_cnt, received_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_logs   = 0;

    always #5 clk = ~clk;

    fpmul_stim_source #(
        .NUM_OPS    (NUM_OPS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SEED_A     (SEED_A),
        .SEED_B     (SEED_B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .log_a        (log_a),
        .log_b        (log_b),
        .log_z        (log_z),
        .log_valid    (log_valid),
        .issued_cnt   (issued_cnt),
        .received_cnt (received_cnt),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference models
    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] to_op(input logic [31:0] s);
        logic [7:0] e;
        e = 8'h78 + {4'h0, s[26:23]};
        return {s[31], e, s[22:0]};
    endfunction

    // Single-precision multiply, round-to-nearest-even, normal operands only.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] r;
        logic        g, st;
        int          e;
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e++;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        r = {1'b0, m} + {24'h0, (g && (st || m[0]))};
        if (r[24]) begin
            e++;
            r = r >> 1;
        end
        return {a[31] ^ b[31], e[7:0], r[22:0]};
    endfunction

    // Scoreboard: operand transfers push expectations, log pulses pop them.
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] z; } rec_t;
    rec_t        sb[$];
    rec_t        rec;
    logic [31:0] lfsr_am = SEED_A;
    logic [31:0] lfsr_bm = SEED_B;
    logic [31:0] ea, eb;

    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            ea = to_op(lfsr_am);
            eb = to_op(lfsr_bm);
            check32("xfer_op_a", op_a, ea);
            check32("xfer_op_b", op_b, eb);
            sb.push_back('{ea, eb, fp_mul(ea, eb)});
            lfsr_am = step(lfsr_am);
            lfsr_bm = step(lfsr_bm);
        end
        if (log_valid) begin
            n_logs++;
            if (sb.size() == 0) begin
                check1("log_unexpected", log_valid, 1'b0);
            end else begin
                rec = sb.pop_front();
                check32("log_a", log_a, rec.a);
                check32("log_b", log_b, rec.b);
                check32("log_z", log_z, rec.z);
            end
        end
    end

    // Multiplier responder with fixed latency; force_* injects stray results.
    typedef struct { logic [31:0] data; int due; } resp_t;
    resp_t       pipe[$];
    int          cyc = 0;
    logic        resp_en = 1'b0;
    logic        resp_valid_r = 1'b0;
    logic [31:0] resp_data_r = '0;
    logic        force_valid = 1'b0;
    logic [31:0] force_data = '0;
    logic        op_fire_n = 1'b0;
    logic        resp_fire_n = 1'b0;
    logic [31:0] fa = '0;
    logic [31:0] fb = '0;

    assign res_valid = resp_valid_r | force_valid;
    assign res_data  = force_valid ? force_data : resp_data_r;

    always @(negedge clk) begin
        op_fire_n   = rst_n && op_valid && op_ready;
        resp_fire_n = rst_n && resp_valid_r && res_ready;
        fa = op_a;
        fb = op_b;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (resp_fire_n) begin
            void'(pipe.pop_front());
            resp_valid_r = 1'b0;
        end
        if (op_fire_n) pipe.push_back('{fp_mul(fa, fb), cyc + LAT - 1});
        if (!rst_n) begin
            pipe.delete();
            resp_valid_r = 1'b0;
        end
        if (pipe.size() > 0 && (resp_valid_r || (resp_en && pipe[0].due <= cyc))) begin
            resp_valid_r = 1'b1;
            resp_data_r  = pipe[0].data;
        end else begin
            resp_valid_r = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) tick();
        check1(tag, done, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [31:0] exp_a, exp_b;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check1("rst_op_valid", op_valid, 1'b0);
        check1("rst_res_ready", res_ready, 1'b0);
        check1("rst_log_valid", log_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_issued", 32'(issued_cnt), 32'd0);
        check32("rst_received", 32'(received_cnt), 32'd0);
        check32("rst_log_z", log_z, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full run, always-ready responder
        resp_en = 1'b1;
        op_ready = 1'b1;
        n_logs = 0;
        check1("idle_op_valid", op_valid, 1'b0);
        pulse_start();
        check1("first_op_valid", op_valid, 1'b1);
        check32("first_op_a", op_a, 32'hC0E12468);
        check1("first_busy", busy, 1'b1);
        wait_done("run1_done");
        check32("run1_issued", 32'(issued_cnt), 32'(NUM_OPS));
        check32("run1_received", 32'(received_cnt), 32'(NUM_OPS));
        check32("run1_log_pulses", 32'(n_logs), 32'(NUM_OPS));
        check1("run1_busy", busy, 1'b0);
        check1("run1_op_valid", op_valid, 1'b0);
        check1("run1_res_ready", res_ready, 1'b0);
        check1("run1_err", err, 1'b0);
        check32("run1_sb_empty", 32'(sb.size()), 32'd0);

        // Stalled offer: operands must hold and the LFSR must not move
        op_ready = 1'b0;
        n_logs = 0;
        pulse_start();
        exp_a = to_op(lfsr_am);
        exp_b = to_op(lfsr_bm);
        check32("stall_issued", 32'(issued_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check1("stall_op_valid", op_valid, 1'b1);
            check32("stall_op_a", op_a, exp_a);
            check32("stall_op_b", op_b, exp_b);
            tick();
        end
        op_ready = 1'b1;
        wait_done("run2_done");
        check32("run2_received", 32'(received_cnt), 32'(NUM_OPS));
        check32("run2_log_pulses", 32'(n_logs), 32'(NUM_OPS));

        // No results returned: issue stops at FIFO depth, then drains once released
        resp_en = 1'b0;
        n_logs = 0;
        pulse_start();
        repeat (20) tick();
        check32("full_issued", 32'(issued_cnt), 32'(FIFO_DEPTH));
        check1("full_op_valid", op_valid, 1'b0);
        check1("full_busy", busy, 1'b1);
        check1("full_done", done, 1'b0);
        check32("full_received", 32'(received_cnt), 32'd0);
        check32("full_sb_depth", 32'(sb.size()), 32'(FIFO_DEPTH));
        resp_en = 1'b1;
        wait_done("run3_done");
        check32("run3_issued", 32'(issued_cnt), 32'(NUM_OPS));
        check32("run3_received", 32'(received_cnt), 32'(NUM_OPS));
        check32("run3_log_pulses", 32'(n_logs), 32'(NUM_OPS));
        check1("run3_err", err, 1'b0);

        // Stray result with the FIFO empty
        resp_en = 1'b0;
        op_ready = 1'b0;
        n_logs = 0;
        pulse_start();
        check1("stray_res_ready", res_ready, 1'b1);
        force_data = 32'h3F800000;
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        check1("stray_err", err, 1'b1);
        check1("stray_log_valid", log_valid, 1'b0);
        check32("stray_received", 32'(received_cnt), 32'd0);
        tick();
        check1("stray_err_sticky", err, 1'b1);
        check32("stray_log_pulses", 32'(n_logs), 32'd0);

        // Reset mid-run after two results
        op_ready = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 100 && received_cnt < 16'd2; i++) tick();
        check1("mid_two_results", received_cnt >= 16'd2, 1'b1);
        rst_n = 1'b0;
        tick();
        sb.delete();
        lfsr_am = SEED_A;
        lfsr_bm = SEED_B;
        check32("mid_rst_issued", 32'(issued_cnt), 32'd0);
        check32("mid_rst_received", 32'(received_cnt), 32'd0);
        check1("mid_rst_err", err, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_op_valid", op_valid, 1'b0);
        check1("mid_rst_log_valid", log_valid, 1'b0);
        check32("mid_rst_log_a", log_a, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        n_logs = 0;
        pulse_start();
        check32("rerun_op_a", op_a, 32'hC0E12468);
        check1("rerun_op_valid", op_valid, 1'b1);
        check32("rerun_issued", 32'(issued_cnt), 32'd0);
        check1("rerun_err", err, 1'b0);
        wait_done("rerun_done");
        check32("rerun_received", 32'(received_cnt), 32'(NUM_OPS));
        check32("rerun_log_pulses", 32'(n_logs), 32'(NUM_OPS));
        check1("rerun_err_end", err, 1'b0);
        check32("rerun_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

endmodule
